// File: rtl/d_debounce.sv
// Debounces an asynchronous level: two-flop synchronizer, then a qualifier that
// accepts a new level only after STABLE consecutive identical synchronized samples.
module d_debounce #(
    parameter int STABLE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       dout,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sync0, sync1;
    logic          dout_nxt, rise_nxt, fall_nxt, busy_nxt;

    // Only sync1 feeds the qualifier; sync0 may be metastable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

    // cnt holds the number of consecutive sync1 samples that differ from dout.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            LOW: begin
                cnt_nxt = '0;
                if (sync1) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!sync1) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                cnt_nxt = '0;
                if (!sync1) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (sync1) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
        dout_nxt = (state_nxt == HIGH) || (state_nxt == WAIT_LO);
        busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_d_debounce.sv
// Bench for d_debounce: directed scenarios plus randomized bounce, all checked
// against a history-window model of the accept rule.
module tb_d_debounce;

    localparam int STABLE = 4;

    logic       clk;
    logic       reset;
    logic       din;
    logic       dout, rise, fall, busy;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    d_debounce #(.STABLE(STABLE)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Downstream D flip-flop fed by dout.
    logic q;
    always @(posedge clk or negedge reset) begin
        if (!reset) q <= 1'b0;
        else        q <= dout;
    end

    // Reference model: the qualifier sees din delayed by two edges; the level
    // flips when the last STABLE samples it saw all differ from the current level.
    logic         m_s0, m_s1, m_dout, m_rise, m_fall, m_busy;
    logic [255:0] m_hist;
    int           m_n;

    function automatic logic model_accept(logic [255:0] h, int n, logic d);
        if (n < STABLE) return 1'b0;
        for (int i = 0; i < STABLE; i++)
            if (h[i] == d) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s0 <= 1'b0; m_s1 <= 1'b0; m_hist <= '0; m_n <= 0;
            m_dout <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_s0   <= din;
            m_s1   <= m_s0;
            m_hist <= {m_hist[254:0], m_s1};
            m_n    <= (m_n < 255) ? m_n + 1 : m_n;
            if (model_accept({m_hist[254:0], m_s1}, m_n + 1, m_dout)) begin
                m_dout <= ~m_dout;
                m_rise <= ~m_dout;
                m_fall <= m_dout;
                m_busy <= 1'b0;
            end else begin
                m_rise <= 1'b0;
                m_fall <= 1'b0;
                m_busy <= (m_s1 != m_dout);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic lvl, input int n);
        din = lvl;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        din   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++;
            if ({dout, rise, fall, busy, dbg_state} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got dout/rise/fall/busy/state=%b want 000000",
                         {dout, rise, fall, busy, dbg_state});
            end
        end
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_tests++;
            if (dout !== (k >= 6) || rise !== (k == 6) || fall !== 1'b0 ||
                busy !== (k >= 3 && k <= 5)) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: got d/r/f/b=%b%b%b%b want %b%b0%b",
                         k, dout, rise, fall, busy, k >= 6, k == 6, k >= 3 && k <= 5);
            end
        end
    endtask

    task automatic test_clean_step();
        settle(1'b0, 10);
        for (int dir = 1; dir >= 0; dir--) begin
            din = dir[0];
            for (int k = 1; k <= 8; k++) begin
                step();
                n_tests++;
                if (dout !== ((k >= 6) ? dir[0] : ~dir[0]) ||
                    rise !== (k == 6 && dir == 1) || fall !== (k == 6 && dir == 0) ||
                    busy !== (k >= 3 && k <= 5)) begin
                    n_fail++;
                    $display("FAIL clean_step dir=%0d edge %0d: got d/r/f/b=%b%b%b%b",
                             dir, k, dout, rise, fall, busy);
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int len = 3; len <= 4; len++) begin
            int  rises = 0;
            logic saw_busy = 1'b0, saw_dout = 1'b0;
            settle(1'b0, 10);
            din = 1'b1;
            for (int k = 0; k < len + 14; k++) begin
                if (k == len) din = 1'b0;
                step();
                rises += int'(rise);
                saw_busy |= busy;
                saw_dout |= dout;
                n_tests++;
                if ({dout, rise, fall, busy} !== {m_dout, m_rise, m_fall, m_busy}) begin
                    n_fail++;
                    $display("FAIL bounce_model len=%0d step %0d: got %b want %b", len, k,
                             {dout, rise, fall, busy}, {m_dout, m_rise, m_fall, m_busy});
                end
            end
            n_tests++;
            if (rises !== len - 3 || saw_dout !== (len == 4) || saw_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bounce_len%0d: got rises=%0d dout_seen=%b busy_seen=%b want %0d %b 1",
                         len, rises, saw_dout, saw_busy, len - 3, len == 4);
            end
        end
    endtask

    task automatic test_toggle();
        settle(1'b0, 10);
        for (int k = 0; k < 20; k++) begin
            din = ((k / 2) % 2 == 0);
            step();
            n_tests++;
            if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL toggle step %0d: got d/r/f=%b%b%b want 000", k, dout, rise, fall);
            end
        end
    endtask

    task automatic test_reset_mid();
        settle(1'b0, 10);
        din = 1'b1;
        for (int k = 0; k < 4; k++) step();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got busy=%b want 1", busy);
        end
        #5 reset = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || dout !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got busy=%b dout=%b state=%0d want 0 0 0",
                     busy, dout, dbg_state);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++;
            if (rise !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_hold: got rise=%b busy=%b want 0 0", rise, busy);
            end
        end
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_tests++;
            if (dout !== (k >= 6) || rise !== (k == 6)) begin
                n_fail++;
                $display("FAIL reset_mid_restart edge %0d: got dout=%b rise=%b want %b %b",
                         k, dout, rise, k >= 6, k == 6);
            end
        end
    endtask

    task automatic test_downstream();
        logic [4:0] pat;
        int   q_changes = 0, fall_k = -10, q_k = -20;
        logic q_prev;
        settle(1'b1, 10);
        q_prev = q;
        pat = 5'b01010;
        for (int k = 0; k < 20; k++) begin
            din = (k < 5) ? pat[4 - k] : 1'b0;
            step();
            if (fall === 1'b1) fall_k = k;
            if (q !== q_prev) begin
                q_changes++;
                q_k = k;
            end
            q_prev = q;
        end
        n_tests++;
        if (q_changes !== 1 || q_k !== fall_k + 1 || q !== 1'b0) begin
            n_fail++;
            $display("FAIL downstream: got q_changes=%0d q_step=%0d fall_step=%0d q=%b want 1 fall+1 0",
                     q_changes, q_k, fall_k, q);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int rises = 0, falls = 0, m_rises = 0, m_falls = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold == 0) begin
                din  = ~din;
                hold = $urandom_range(1, 2 * STABLE + 2);
            end
            hold--;
            step();
            rises += int'(rise); falls += int'(fall);
            m_rises += int'(m_rise); m_falls += int'(m_fall);
            n_tests++;
            if ({dout, rise, fall, busy} !== {m_dout, m_rise, m_fall, m_busy} ||
                (rise & fall) !== 1'b0) begin
                n_fail++;
                $display("FAIL random step %0d: got d/r/f/b=%b want %b", k,
                         {dout, rise, fall, busy}, {m_dout, m_rise, m_fall, m_busy});
            end
        end
        n_tests++;
        if (rises !== m_rises || falls !== m_falls) begin
            n_fail++;
            $display("FAIL random_counts: got rises=%0d falls=%0d want %0d %0d",
                     rises, falls, m_rises, m_falls);
        end
    endtask

    initial begin
        #1ms;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_toggle();
        test_reset_mid();
        test_downstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
